// File: rtl/uart_nic_pkg.sv
// Shared types and framing constants for the uart_nic NIC-side UART bridge.
package uart_nic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_nic_if.sv
// OS-side byte interface of uart_nic: push/pop strobes, RX head, status and sticky flags.
interface uart_nic_if;
  // Handshake: write_nic pushes send_data_to_nic on each cycle it is high (dropped while
  // tx_full); rec_data_from_nic is valid while send_data_i=1 and read_nic pops it at the
  // edge; read_nic with send_data_i=0 is ignored.
  logic       write_nic;
  logic [7:0] send_data_to_nic;
  logic       read_nic;
  logic [7:0] rec_data_from_nic;
  logic       send_data_i;
  logic       tx_full;
  logic       tx_busy;
  logic       err_clear;
  logic       rx_overflow;
  logic       rx_frame_err;

  modport master (
    output write_nic, send_data_to_nic, read_nic, err_clear,
    input  rec_data_from_nic, send_data_i, tx_full, tx_busy, rx_overflow, rx_frame_err
  );

  modport slave (
    input  write_nic, send_data_to_nic, read_nic, err_clear,
    output rec_data_from_nic, send_data_i, tx_full, tx_busy, rx_overflow, rx_frame_err
  );
endinterface

// File: rtl/uart_nic_sync_fifo.sv
// Show-ahead synchronous FIFO; the caller qualifies i_push, pops on empty are ignored.
module nic_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head reads as zero when empty so stale entries never leak after reset.
  assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_nic.sv
// NIC end of the OS<->NIC byte link: TX FIFO -> 8N1 serialiser, deserialiser -> RX FIFO.
// Optional macro WRITE_EDGE_DETECT_EN: push only on a 0->1 transition of write_nic.
module uart_nic
  import uart_nic_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  uart_nic_if.slave   os,
  input  logic        uart_rx,
  output logic        uart_tx,
  output uart_state_t o_tx_state,
  output uart_state_t o_rx_state
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  // ---------------- write strobe qualification ----------------
  logic w_write_evt;
`ifdef WRITE_EDGE_DETECT_EN
  logic r_write_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_write_d <= 1'b0;
    else     r_write_d <= os.write_nic;
  end
  assign w_write_evt = os.write_nic && !r_write_d;
`else
  assign w_write_evt = os.write_nic;
`endif

  // ---------------- TX path ----------------
  logic [7:0]  w_tx_head;
  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [AW:0] w_tx_count;
  logic        w_tx_bit_end, w_tx_stop_done;

  uart_state_t r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_uart_tx;

  // A push while full is dropped even if the FSM pops in the same cycle.
  assign w_tx_push      = w_write_evt && !w_tx_full;
  assign w_tx_bit_end   = (r_tx_cnt == BIT_LAST);
  assign w_tx_stop_done = (r_tx_state == ST_STOP) && w_tx_bit_end && (r_tx_idx == STOP_LAST);
  assign w_tx_pop       = !w_tx_empty && ((r_tx_state == ST_IDLE) || w_tx_stop_done);

  nic_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (os.send_data_to_nic),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_uart_tx  <= IDLE_LEVEL;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_cnt   <= '0;
            r_uart_tx  <= ~IDLE_LEVEL;
            r_tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_uart_tx  <= r_tx_shift[0];
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == IDX_LAST) begin
              r_tx_idx   <= '0;
              r_uart_tx  <= IDLE_LEVEL;
              r_tx_state <= ST_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_uart_tx  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx != STOP_LAST) begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end else if (w_tx_pop) begin
              // Next byte waiting: straight into its start bit, no idle gap.
              r_tx_shift <= w_tx_head;
              r_uart_tx  <= ~IDLE_LEVEL;
              r_tx_state <= ST_START;
            end else begin
              r_tx_state <= ST_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic w_rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rx;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  assign w_rx_fall = r_rx_prev && !r_rx_sync2;

  uart_state_t   r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          r_rx_wait_high;
  logic          w_rx_bit_end, w_rx_half_end, w_rx_stop_sample;
  logic          w_rx_byte_ok, w_rx_byte_bad;
  logic [7:0]    w_rx_head;
  logic          w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [AW:0]   w_rx_count;
  logic          r_rx_overflow, r_rx_frame_err;

  assign w_rx_bit_end     = (r_rx_cnt == BIT_LAST);
  assign w_rx_half_end    = (r_rx_cnt == HALF_LAST);
  assign w_rx_stop_sample = (r_rx_state == ST_STOP) && !r_rx_wait_high && w_rx_bit_end;
  assign w_rx_byte_ok     = w_rx_stop_sample && r_rx_sync2;
  assign w_rx_byte_bad    = w_rx_stop_sample && !r_rx_sync2;
  assign w_rx_pop         = os.read_nic && !w_rx_empty;
  // A same-cycle OS pop frees the slot, so a full FIFO still accepts the byte.
  assign w_rx_push        = w_rx_byte_ok && (!w_rx_full || w_rx_pop);

  nic_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state     <= ST_IDLE;
      r_rx_cnt       <= '0;
      r_rx_idx       <= '0;
      r_rx_shift     <= '0;
      r_rx_wait_high <= 1'b0;
    end else begin
      case (r_rx_state)
        ST_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_rx_half_end) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
            if (r_rx_idx == IDX_LAST) begin
              r_rx_wait_high <= 1'b0;
              r_rx_state     <= ST_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // After a bad stop bit, hold here until the line returns high.
          if (r_rx_wait_high) begin
            if (r_rx_sync2) begin
              r_rx_wait_high <= 1'b0;
              r_rx_state     <= ST_IDLE;
            end
          end else if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            if (r_rx_sync2) r_rx_state     <= ST_IDLE;
            else            r_rx_wait_high <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a set event beats err_clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_overflow  <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_rx_byte_ok && w_rx_full && !w_rx_pop) r_rx_overflow <= 1'b1;
      else if (os.err_clear)                      r_rx_overflow <= 1'b0;
      if (w_rx_byte_bad)                          r_rx_frame_err <= 1'b1;
      else if (os.err_clear)                      r_rx_frame_err <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign uart_tx              = r_uart_tx;
  assign os.tx_full           = w_tx_full;
  assign os.tx_busy           = (r_tx_state != ST_IDLE) || (w_tx_count != '0);
  assign os.send_data_i       = (w_rx_count != '0);
  assign os.rec_data_from_nic = w_rx_head;
  assign os.rx_overflow       = r_rx_overflow;
  assign os.rx_frame_err      = r_rx_frame_err;
  assign o_tx_state           = r_tx_state;
  assign o_rx_state           = r_rx_state;

endmodule

// File: tb/tb_uart_nic.sv
// Directed-sequence bench for uart_nic with random payloads, a serial-line monitor and
// a bounded-queue model of the RX FIFO.
module tb_uart_nic;
  import uart_nic_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_drv = 1'b1;
  logic        uart_rx;
  logic        uart_tx;
  uart_state_t tx_state, rx_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];      // expected RX FIFO contents, oldest first
  logic [7:0] tx_exp_q[$];   // expected bytes on uart_tx
  logic       exp_ovf;
  logic [7:0] mon_data_q[$];
  int         mon_start_q[$];
  logic       mon_stop_q[$];
  logic [7:0] mon_d;
  int         mon_t;

  uart_nic_if nic_if();

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_nic #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .os         (nic_if),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .o_tx_state (tx_state),
    .o_rx_state (rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000ns");
    $fatal(1, "watchdog");
  end

  // ---------------- serial-line monitor on uart_tx ----------------
  always begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      mon_t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_d[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      mon_data_q.push_back(mon_d);
      mon_start_q.push_back(mon_t);
      mon_stop_q.push_back(uart_tx);
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    nic_if.send_data_to_nic = b;
    nic_if.write_nic = 1'b1;
    tick();
    nic_if.write_nic = 1'b0;
    tick();
  endtask

  task automatic os_pop_expect(input logic [7:0] exp);
    @(negedge clk);
    check("rx_pending", nic_if.send_data_i, 1'b1);
    check("rx_head", nic_if.rec_data_from_nic, exp);
    @(posedge clk);
    #1;
    nic_if.read_nic = 1'b1;
    tick();
    nic_if.read_nic = 1'b0;
  endtask

  task automatic pulse_err_clear();
    nic_if.err_clear = 1'b1;
    tick();
    nic_if.err_clear = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) tick();
    end
    rx_drv = stop_bit;
    repeat (CPB) tick();
    rx_drv = 1'b1;
  endtask

  // RX model: a bounded queue; a good frame arriving while full is lost.
  task automatic rx_model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic expect_tx_frame(input logic [7:0] b);
    logic e;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (j < CPB)          e = 1'b0;
      else if (j < 9 * CPB) e = b[(j / CPB) - 1];
      else                  e = 1'b1;
      check("tx_bit", uart_tx, e);
    end
  endtask

  task automatic wait_tx_idle(input int max_cyc);
    int n = 0;
    while (nic_if.tx_busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_timeout", nic_if.tx_busy, 1'b0);
  endtask

  task automatic clear_mon();
    mon_data_q.delete();
    mon_start_q.delete();
    mon_stop_q.delete();
  endtask

  task automatic check_tx_seen();
    check("tx_frame_count", mon_data_q.size(), tx_exp_q.size());
    for (int i = 0; i < tx_exp_q.size() && i < mon_data_q.size(); i++) begin
      check("tx_frame_data", mon_data_q[i], tx_exp_q[i]);
      check("tx_frame_stop", mon_stop_q[i], 1'b1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b, b2;
    int lows;

    nic_if.write_nic        = 1'b0;
    nic_if.send_data_to_nic = 8'h00;
    nic_if.read_nic         = 1'b0;
    nic_if.err_clear        = 1'b0;
    exp_ovf                 = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_full", nic_if.tx_full, 1'b0);
    check("rst_tx_busy", nic_if.tx_busy, 1'b0);
    check("rst_send_data_i", nic_if.send_data_i, 1'b0);
    check("rst_rec_data", nic_if.rec_data_from_nic, 8'h00);
    check("rst_rx_overflow", nic_if.rx_overflow, 1'b0);
    check("rst_rx_frame_err", nic_if.rx_frame_err, 1'b0);
    check("rst_tx_state", tx_state, ST_IDLE);
    check("rst_rx_state", rx_state, ST_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single-byte TX: 0xA5 then a random byte, exact bit timing
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      nic_if.send_data_to_nic = b;
      nic_if.write_nic = 1'b1;
      tick();
      nic_if.write_nic = 1'b0;
      @(negedge clk);
      check("tx_pre_start_line", uart_tx, 1'b1);
      check("tx_busy_after_write", nic_if.tx_busy, 1'b1);
      @(posedge clk);
      #1;
      expect_tx_frame(b);
      @(negedge clk);
      check("tx_busy_after_frame", nic_if.tx_busy, 1'b0);
      repeat (3) tick();
    end

    // Loopback burst of 3 random bytes, back-to-back frames
    clear_mon();
    tx_exp_q.delete();
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_exp_q.push_back(b);
      rx_model_push(b);
      write_byte(b);
    end
    wait_tx_idle(10 * FRAME);
    repeat (8) tick();
    loop_en = 1'b0;
    check_tx_seen();
    for (int i = 1; i < mon_start_q.size(); i++)
      check("tx_back_to_back", mon_start_q[i] - mon_start_q[i-1], FRAME);
    while (exp_q.size() > 0) os_pop_expect(exp_q.pop_front());
    nic_if.read_nic = 1'b1;   // trailing pop on empty
    tick();
    nic_if.read_nic = 1'b0;
    @(negedge clk);
    check("rx_empty_after_pops", nic_if.send_data_i, 1'b0);
    check("no_overflow_loopback", nic_if.rx_overflow, 1'b0);
    check("no_frame_err_loopback", nic_if.rx_frame_err, 1'b0);

    // TX FIFO full: 6 writes, 5 transmitted
    clear_mon();
    tx_exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 5) tx_exp_q.push_back(b);
      write_byte(b);
      if (i >= 4) begin
        @(negedge clk);
        check("tx_full_asserted", nic_if.tx_full, 1'b1);
      end
    end
    wait_tx_idle(8 * FRAME);
    repeat (4) tick();
    check_tx_seen();
    check("tx_full_released", nic_if.tx_full, 1'b0);

    // RX overflow: 5 frames, no reads
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx_frame(b, 1'b1);
      rx_model_push(b);
    end
    repeat (6) tick();
    @(negedge clk);
    check("rx_overflow_set", nic_if.rx_overflow, exp_ovf);
    check("rx_pending_full", nic_if.send_data_i, 1'b1);
    check("rx_head_first", nic_if.rec_data_from_nic, exp_q[0]);
    check("no_frame_err_ovf", nic_if.rx_frame_err, 1'b0);
    @(posedge clk);
    #1;
    pulse_err_clear();
    @(negedge clk);
    check("rx_overflow_cleared", nic_if.rx_overflow, 1'b0);
    check("rx_head_after_clear", nic_if.rec_data_from_nic, exp_q[0]);
    while (exp_q.size() > 0) os_pop_expect(exp_q.pop_front());
    @(negedge clk);
    check("rx_drained", nic_if.send_data_i, 1'b0);

    // Frame error, recovery, then a 1-cycle glitch
    @(posedge clk);
    #1;
    b = 8'($urandom_range(0, 255));
    send_rx_frame(b, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("rx_frame_err_set", nic_if.rx_frame_err, 1'b1);
    check("rx_frame_err_no_push", nic_if.send_data_i, 1'b0);
    check("rx_frame_err_no_ovf", nic_if.rx_overflow, 1'b0);
    @(posedge clk);
    #1;
    pulse_err_clear();
    @(negedge clk);
    check("rx_frame_err_cleared", nic_if.rx_frame_err, 1'b0);
    @(posedge clk);
    #1;
    b2 = 8'($urandom_range(0, 255));
    send_rx_frame(b2, 1'b1);
    rx_model_push(b2);
    repeat (6) tick();
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("glitch_no_frame_err", nic_if.rx_frame_err, 1'b0);
    check("glitch_rx_state_idle", rx_state, ST_IDLE);
    while (exp_q.size() > 0) os_pop_expect(exp_q.pop_front());
    @(negedge clk);
    check("glitch_no_push", nic_if.send_data_i, 1'b0);

    // Reset mid-frame with bytes still queued
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
    repeat (12) tick();
    @(negedge clk);
    check("midframe_busy", nic_if.tx_busy, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_uart_tx", uart_tx, 1'b1);
    check("rst_mid_tx_busy", nic_if.tx_busy, 1'b0);
    check("rst_mid_tx_full", nic_if.tx_full, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("rst_fifo_discarded", lows, 0);
    check("rst_stays_idle", nic_if.tx_busy, 1'b0);

    // Held write_nic
    @(posedge clk);
    #1;
    clear_mon();
    tx_exp_q.delete();
`ifdef WRITE_EDGE_DETECT_EN
    b = 8'($urandom_range(0, 255));
    tx_exp_q.push_back(b);
    nic_if.send_data_to_nic = b;
    nic_if.write_nic = 1'b1;
    repeat (20) tick();
    nic_if.write_nic = 1'b0;
`else
    b  = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    tx_exp_q.push_back(b);
    tx_exp_q.push_back(b2);
    nic_if.send_data_to_nic = b;
    nic_if.write_nic = 1'b1;
    tick();
    nic_if.send_data_to_nic = b2;
    tick();
    nic_if.write_nic = 1'b0;
`endif
    wait_tx_idle(6 * FRAME);
    repeat (4) tick();
    check_tx_seen();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_nic.md
Name: uart_nic

Overview:
- Network-interface end of the OS↔NIC byte interface. Accepts bytes pushed by the OS simulator (write_nic / send_data_to_nic) and buffers them in a TX FIFO. Serialises them onto a UART line, 8N1, LSB first.
- Deserialises the incoming UART line into an RX FIFO. Advertises pending data on send_data_i and presents the FIFO head on rec_data_from_nic for the OS to pop with read_nic.
- Sits between the OS simulator block and the board GPIO UART pins.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be >= 4.
- FIFO_DEPTH, 8, entries per FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- write_nic  in  1  push strobe; one byte pushed per cycle it is high
- send_data_to_nic  in  8  byte to transmit, sampled when write_nic is high
- read_nic  in  1  pop strobe for the RX FIFO head
- rec_data_from_nic  out  8  RX FIFO head (show-ahead); valid while send_data_i=1
- send_data_i  out  1  RX FIFO non-empty
- uart_rx  in  1  serial input, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FSM not IDLE, or TX FIFO non-empty
- err_clear  in  1  clears the sticky error flags
- rx_overflow  out  1  sticky: received byte dropped because RX FIFO was full
- rx_frame_err  out  1  sticky: stop bit sampled low

Behaviour:
- Reset values:
  - uart_tx=1; all other outputs 0; rec_data_from_nic=0.
  - Both FIFOs empty; both FSMs in IDLE; synchroniser flops =1.
- Reset asserted mid-frame aborts immediately: uart_tx=1, FIFO contents discarded.
- TX FIFO:
  - Push on write_nic=1 when not full.
  - Push while full is dropped, even if the TX FSM pops in the same cycle; no flag is raised.
  - tx_full is combinational from the count.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register and enter START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; 3-bit index counter.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- TX latency: byte written at edge k into an empty FIFO with FSM idle → uart_tx falls after edge k+1. A frame lasts exactly 10*CLKS_PER_BIT cycles.
- uart_tx is driven from a register (glitch-free).
- RX input path:
  - 2-flop synchroniser on uart_rx.
  - Baud counter restarts on falling-edge detection in IDLE.
- RX FSM states: IDLE, START, DATA, STOP.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If high, it is a false start → IDLE, nothing pushed. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, mid-bit, LSB first.
  - STOP: sample mid-bit.
    - High: push the byte into the RX FIFO. If the FIFO is full, drop the byte and set rx_overflow.
    - Low: discard the byte, set rx_frame_err. Return to IDLE only after the line is seen high.
- RX FIFO / OS interface:
  - send_data_i = non-empty, combinational from the count.
  - A pop happens at an edge where read_nic=1 and the FIFO is non-empty.
  - read_nic while empty is ignored; no state change, no flag. The OS registers read_nic one cycle behind send_data_i, so one trailing pop on empty is normal.
  - RX push and OS pop in the same cycle are both honoured, including when the FIFO is full.
- Sticky flags:
  - Cleared when err_clear=1.
  - A set event in the same cycle as err_clear wins; the flag stays 1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider to distinguish full from empty.

Optional Feature:
- Macro WRITE_EDGE_DETECT_EN.
- Defined: register write_nic. A push occurs only on a 0→1 transition of write_nic; data is sampled in that same cycle. A write_nic held high (button held) pushes exactly one byte.
- Undefined: every cycle with write_nic=1 is a push attempt.
- Reset value of the edge register is 0, so write_nic high immediately out of reset counts as an edge.

Decomposition:
- Package uart_nic_pkg holds:
  - the state enum typedef shared by the TX and RX FSMs (IDLE/START/DATA/STOP);
  - constants for data bits (8), stop bits (1) and idle line level (1).
- One sub-module: nic_sync_fifo.
  - Show-ahead, parameterised depth and width, async reset.
  - Exposes full/empty/count.
  - Instantiated twice, once for TX and once for RX.
- The FSMs stay inline in uart_nic.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=4. Write 0xA5 once → uart_tx low starting 1 cycle later. Bits 1,0,1,0,0,1,0,1 every 4 cycles, then stop high. 40 cycles total; tx_busy drops afterwards.
- Loopback uart_tx→uart_rx, burst-write 0x01,0x02,0x03 → frames back-to-back with no idle gap. send_data_i rises; the OS pop sequence reads 0x01,0x02,0x03; send_data_i=0 afterwards. The extra read_nic pop on empty is harmless.
- Write 6 bytes back-to-back into the TX FIFO with depth 4 → tx_full asserts. The first byte is popped by the FSM, so exactly 5 bytes are transmitted.
- Drive 5 frames into uart_rx with no reads → 4 bytes are held and rx_overflow=1. err_clear → 0. The FIFO head is still the first byte.
- Frame with stop bit low → rx_frame_err=1 and nothing pushed. A 1-cycle low glitch on uart_rx → no push and no error.
- Assert rst mid-TX-frame → uart_tx=1 immediately, tx_busy=0, FIFO empty. With WRITE_EDGE_DETECT_EN, write_nic held high for 20 cycles → exactly one frame is sent.
